// File: rtl/memory_access.sv
// Memory stage of the 64-bit RISC-V pipeline.
//
// Accepts the execute-stage bundle and turns loads and stores into data-bus
// requests. The stage holds until the bus responds. It then presents a
// registered writeback bundle downstream through a valid/ready handshake.
//
// Ports
//   clk, reset            clock; asynchronous active-low reset
//   in_*                  execute bundle (valid/ready, result/address, store
//                         data, memread/memwrite/regwrite, dst)
//   dreq_*                data-bus request (valid, addr, byte strobe, data)
//   dresp_*               data-bus response (single-cycle data_ok, load data)
//   out_*                 writeback bundle (valid/ready, result, regwrite,
//                         dst, misalign)
module memory_access #(
   parameter int unsigned XLEN = 64,
   parameter int unsigned REGW = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_result,
   input  logic [XLEN-1:0] in_memdata,
   input  logic            in_memread,
   input  logic            in_memwrite,
   input  logic            in_regwrite,
   input  logic [REGW-1:0] in_dst,
   output logic            dreq_valid,
   output logic [XLEN-1:0] dreq_addr,
   output logic [7:0]      dreq_strobe,
   output logic [XLEN-1:0] dreq_data,
   input  logic            dresp_data_ok,
   input  logic [XLEN-1:0] dresp_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result,
   output logic            out_regwrite,
   output logic [REGW-1:0] out_dst,
   output logic            out_misalign
);

   typedef enum logic [1:0] {StIdle, StMem, StOut} state_e;

   state_e            state_q, state_d;
   // result_q is the bus address while in StMem, then the writeback result.
   logic [XLEN-1:0]   result_q, result_d;
   logic [XLEN-1:0]   data_q, data_d;
   logic              is_load_q, is_load_d;
   logic              regwrite_q, regwrite_d;
   logic [REGW-1:0]   dst_q, dst_d;
   logic              misalign_q, misalign_d;

   logic              accept;
   logic              is_mem;
   logic              is_mis;

   assign in_ready = (state_q == StIdle) | ((state_q == StOut) & out_ready);
   assign accept   = in_valid & in_ready;
   assign is_mem   = in_memread | in_memwrite;
   assign is_mis   = is_mem & (in_result[2:0] != 3'b000);

   always_comb begin
      state_d    = state_q;
      result_d   = result_q;
      data_d     = data_q;
      is_load_d  = is_load_q;
      regwrite_d = regwrite_q;
      dst_d      = dst_q;
      misalign_d = misalign_q;

      unique case (state_q)
         StMem: begin
            if (dresp_data_ok) begin
               state_d = StOut;
               // A store reports its latched address, so result_q stays put.
               if (is_load_q) result_d = dresp_data;
            end
         end
         StOut: begin
            if (out_ready) state_d = StIdle;
         end
         default: ;
      endcase

      // A new bundle overrides the StOut drain, giving back-to-back transfers.
      if (accept) begin
         result_d   = in_result;
         data_d     = in_memdata;
         // memread together with memwrite behaves as a store.
         is_load_d  = in_memread & ~in_memwrite;
         regwrite_d = in_regwrite & ~is_mis;
         dst_d      = in_dst;
         misalign_d = is_mis;
         state_d    = (is_mem & ~is_mis) ? StMem : StOut;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         result_q   <= '0;
         data_q     <= '0;
         is_load_q  <= 1'b0;
         regwrite_q <= 1'b0;
         dst_q      <= '0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         result_q   <= result_d;
         data_q     <= data_d;
         is_load_q  <= is_load_d;
         regwrite_q <= regwrite_d;
         dst_q      <= dst_d;
         misalign_q <= misalign_d;
      end
   end

   assign dreq_valid   = (state_q == StMem);
   assign dreq_addr    = result_q;
   assign dreq_data    = data_q;
   assign dreq_strobe  = (dreq_valid && !is_load_q) ? 8'hFF : 8'h00;

   assign out_valid    = (state_q == StOut);
   assign out_result   = result_q;
   assign out_regwrite = regwrite_q;
   assign out_dst      = dst_q;
   assign out_misalign = misalign_q;

endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- Memory stage: consumer of the execute stage's output bundle (ALU result, store data, memread/memwrite/regwrite, dst).
- Turns loads and stores into data-bus transactions and holds the stage until the bus responds.
- Presents a registered writeback bundle downstream with a valid/ready handshake.
- Sits between the execute stage and writeback in the 64-bit RISC-V pipeline.

Parameters:
- XLEN, 64, data/address width.
- REGW, 5, register index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- in_valid  in  1  execute bundle valid.
- in_ready  out  1  stage accepts bundle this cycle.
- in_result  in  XLEN  ALU result; effective address for memory ops.
- in_memdata  in  XLEN  store data.
- in_memread  in  1  load.
- in_memwrite  in  1  store.
- in_regwrite  in  1  writes rd.
- in_dst  in  REGW  destination register.
- dreq_valid  out  1  data-bus request.
- dreq_addr  out  XLEN  request address.
- dreq_strobe  out  8  byte enables; 8'hFF for store, 8'h00 for load.
- dreq_data  out  XLEN  store data.
- dresp_data_ok  in  1  bus response; single-cycle pulse.
- dresp_data  in  XLEN  load data, valid with dresp_data_ok.
- out_valid  out  1  writeback bundle valid.
- out_ready  in  1  downstream accepts.
- out_result  out  XLEN  load data, or ALU result for non-load ops.
- out_regwrite  out  1  registered in_regwrite; forced 0 on misaligned op.
- out_dst  out  REGW  registered in_dst.
- out_misalign  out  1  memory op with in_result[2:0] != 0.

Behaviour:
- Reset value of every registered output is 0; state = IDLE.
- Reset is asynchronous: assertion at any time, including mid-transaction, drops dreq_valid and out_valid immediately. The outstanding bus request is abandoned.
- States:
  - IDLE: nothing held.
  - MEM: bus request outstanding.
  - OUT: result held for downstream.
- in_ready = (state==IDLE) | (state==OUT & out_ready).
- A transfer occurs when in_valid & in_ready.
- Accept, non-memory op (memread=memwrite=0):
  - Next cycle: state OUT, out_valid=1, out_result=in_result.
  - Latency 1 cycle.
- Accept, memory op, aligned:
  - Latch address, data and kind; state MEM.
  - dreq_valid=1 from the next cycle.
  - addr/strobe/data held constant until dresp_data_ok.
- Accept, memory op, misaligned (in_result[2:0]!=0):
  - No bus request.
  - Go to OUT with out_misalign=1, out_regwrite=0, out_result=in_result.
- memread & memwrite both set: treated as a store.
- MEM and dresp_data_ok=1:
  - dreq_valid drops the next cycle; state OUT.
  - Load: out_result=dresp_data.
  - Store: out_result=in_result (latched address).
  - Minimum memory-op latency: request cycle + response cycle.
- dresp_data_ok in IDLE or OUT: ignored, with no state change.
- OUT:
  - out_valid=1 and all out_* stable until out_ready.
  - out_ready & in_valid same cycle: back-to-back transfer, no bubble. The new bundle goes to OUT or MEM per the rules above.
  - out_ready without in_valid: go to IDLE, out_valid=0.
- No new bundle is accepted while in MEM (in_ready=0), so at most one outstanding bus request.
- Bundle fields not listed above pass through unchanged. out_dst is always the accepted in_dst.

Test Plan:
1. Non-memory op: in_result=64'h1234, regwrite=1, dst=5, out_ready=1. Required: out_valid one cycle later, out_result=64'h1234, out_dst=5, no dreq_valid.
2. Load at 64'h80000008, dresp_data_ok returned 3 cycles later with dresp_data=64'hDEADBEEF. Required: dreq_valid high with strobe 8'h00 for exactly those cycles; in_ready=0 throughout; out_result=64'hDEADBEEF; out_regwrite=1.
3. Store at 64'h80000010, data 64'hCAFE. Required: dreq_strobe=8'hFF, dreq_data=64'hCAFE held until data_ok; out_result=64'h80000010.
4. Load at 64'h80000004 (misaligned). Required: no dreq_valid; out_misalign=1; out_regwrite=0.
5. Backpressure: out_ready=0 for 4 cycles with in_valid=1. Required: out_* stable; in_ready=0. Then out_ready=1 with a new ALU op: same-cycle acceptance and the next result one cycle later.
6. Reset: drive reset=0 mid-MEM. Required: dreq_valid and out_valid fall asynchronously. After release, a stray dresp_data_ok is ignored and state is IDLE with in_ready=1.
